// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, instruction field positions and the ALU.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int SH_MSB = 10, SH_LSB = 6;
  localparam int FN_MSB = 5,  FN_LSB = 0;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT, SLTU, SLL, LUI} alu_op_t;
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] sh);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      SLT:     return {31'b0, $signed(a) < $signed(b)};
      SLTU:    return {31'b0, a < b};
      SLL:     return b << sh;
      default: return {b[15:0], 16'h0};
    endcase
  endfunction
endpackage

// File: rtl/mips_exec_unit_if.sv
// mips_exec_unit_if: link between the unified memory block (master) and the execute unit (slave).
interface mips_exec_unit_if;
  logic        E;
  logic [31:0] I;
  logic [31:0] PC;
  logic [31:0] mem_rdata;
  logic [31:0] next_pc;
  logic [29:0] addr_in;
  logic [31:0] data_in;
  logic        S;
  modport master(output E, I, PC, mem_rdata, input next_pc, addr_in, data_in, S);
  modport slave(input E, I, PC, mem_rdata, output next_pc, addr_in, data_in, S);
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, r0 fixed at zero.
module mips_regfile #(
  parameter int MIRROR = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_mirror
);
  logic [31:0] r_mem [32];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    else if (i_we && i_wa != 5'd0) r_mem[i_wa] <= i_wd;
  end
  assign o_rd1    = r_mem[i_ra1];
  assign o_rd2    = r_mem[i_ra2];
  assign o_mirror = r_mem[5'(MIRROR)];
endmodule

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: execute/writeback stage with regfile, ALU, branch resolution; EXEC_OVF_TRAP_EN adds overflow trap.
module mips_exec_unit import mips_pkg::*; #(
  parameter int OUT_REG = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  mips_exec_unit_if.slave  mem,
  output logic [31:0]      out_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
`ifdef EXEC_OVF_TRAP_EN
  ,
  output logic             ovf
`endif
);
  logic [31:0] r_ir;
  logic r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic [31:0] w_src, w_a, w_rt, w_b, w_simm, w_zimm, w_res, w_wd, w_pc4;
  logic [5:0] w_opc, w_fn;
  logic [4:0] w_wa;
  alu_op_t w_op;
  logic w_we, w_legal, w_taken, w_commit;
  // Fetch resolves branches from I; execute works only from IR, so the regfile reads follow the phase.
  assign w_src  = mem.E ? r_ir : mem.I;
  assign w_opc  = w_src[OP_MSB:OP_LSB];
  assign w_fn   = w_src[FN_MSB:FN_LSB];
  assign w_simm = {{16{w_src[15]}}, w_src[15:0]};
  assign w_zimm = {16'h0, w_src[15:0]};
  mips_regfile #(.MIRROR(OUT_REG)) u_rf (
    .clk(clk), .rst(rst),
    .i_ra1(w_src[RS_MSB:RS_LSB]), .i_ra2(w_src[RT_MSB:RT_LSB]),
    .o_rd1(w_a), .o_rd2(w_rt),
    .i_we(w_commit), .i_wa(w_wa), .i_wd(w_wd),
    .o_mirror(out_reg)
  );
  assign w_pc4   = mem.PC + 32'd4;
  assign w_taken = (w_opc == OP_BEQ && w_a == w_rt) || (w_opc == OP_BNE && w_a != w_rt);
  assign mem.next_pc = w_opc == OP_J ? {w_pc4[31:28], w_src[25:0], 2'b00} :
                       w_taken ? w_pc4 + {w_simm[29:0], 2'b00} : w_pc4;
  always_comb begin
    w_op = ADD;
    w_b = w_simm;
    w_we = 1'b1;
    w_legal = 1'b1;
    w_wa = w_src[RT_MSB:RT_LSB];
    case (w_opc)
      OP_RTYPE: begin
        w_b = w_rt;
        w_wa = w_src[RD_MSB:RD_LSB];
        case (w_fn)
          F_ADD, F_ADDU: w_op = ADD;
          F_SUB, F_SUBU: w_op = SUB;
          F_AND:         w_op = AND;
          F_OR:          w_op = OR;
          F_SLT:         w_op = SLT;
          F_SLTU:        w_op = SLTU;
          F_SLL:         w_op = SLL;
          default: begin
            w_we = 1'b0;
            w_legal = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: w_op = ADD;
      OP_ANDI: begin
        w_op = AND;
        w_b = w_zimm;
      end
      OP_ORI: begin
        w_op = OR;
        w_b = w_zimm;
      end
      OP_LUI:  w_op = LUI;
      OP_SLTI: w_op = SLT;
      OP_SW, OP_BEQ, OP_BNE, OP_J: w_we = 1'b0;
      default: begin
        w_we = 1'b0;
        w_legal = 1'b0;
      end
    endcase
  end
  assign w_res       = alu(w_op, w_a, w_b, w_src[SH_MSB:SH_LSB]);
  assign w_wd        = w_opc == OP_LW ? mem.mem_rdata : w_res;
  assign mem.addr_in = 30'((w_a + w_simm) >> 2);
  assign mem.data_in = w_rt;
  assign mem.S       = mem.E & (w_opc == OP_SW) & ~rst;
`ifdef EXEC_OVF_TRAP_EN
  logic r_ovf, w_chk_ovf, w_ovf;
  assign w_chk_ovf = w_opc == OP_ADDI || (w_opc == OP_RTYPE && (w_fn == F_ADD || w_fn == F_SUB));
  assign w_ovf = w_chk_ovf & (w_op == SUB ? w_a[31] != w_b[31] : w_a[31] == w_b[31]) & (w_res[31] != w_a[31]);
  assign w_commit = mem.E & w_we & ~w_ovf;
  assign ovf = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (mem.E && w_ovf) r_ovf <= 1'b1;
  end
`else
  assign w_commit = mem.E & w_we;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= '0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else if (!mem.E) r_ir <= mem.I;
    else begin
      r_instret <= r_instret + CNT_W'(1);
      r_illegal <= r_illegal | ~w_legal;
    end
  end
  assign illegal = r_illegal;
  assign instret = r_instret;
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: ISA-level reference model, scoreboard queues, directed programs plus random instruction stream.
module tb_mips_exec_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mips_exec_unit_if mem();
  logic [31:0] out_reg;
  logic illegal;
  logic [31:0] instret;
`ifdef EXEC_OVF_TRAP_EN
  logic ovf;
`endif
  mips_exec_unit dut (
    .clk(clk), .rst(rst), .mem(mem), .out_reg(out_reg), .illegal(illegal), .instret(instret)
`ifdef EXEC_OVF_TRAP_EN
    , .ovf(ovf)
`endif
  );

  logic [31:0] dmem [64];
  always_comb mem.mem_rdata = dmem[mem.addr_in[5:0]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 64; i++) dmem[i] <= '0;
    else if (mem.E && mem.S) dmem[mem.addr_in[5:0]] <= mem.data_in;
  end

  typedef struct { logic [31:0] npc, outr, icnt; logic ill, ovf; } fexp_t;
  typedef struct { logic s, lw; logic [29:0] addr; logic [31:0] data; } xexp_t;
  fexp_t fq[$];
  xexp_t xq[$];
  fexp_t mf;
  xexp_t mx;
  int n_chk = 0, n_pass = 0, s_cnt = 0;
  logic [31:0] last_npc, last_saddr;
  logic [31:0] m_reg [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc, m_icnt;
  logic m_ill, m_ovf;
  logic [31:0] prog[$];
  logic [5:0] fns [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00};

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem.S) s_cnt++;
      if (!mem.E && fq.size() > 0) begin
        mf = fq.pop_front();
        last_npc = mem.next_pc;
        chk("next_pc", mem.next_pc, mf.npc);
        chk("out_reg", out_reg, mf.outr);
        chk("instret", instret, mf.icnt);
        chk("illegal", {31'b0, illegal}, {31'b0, mf.ill});
`ifdef EXEC_OVF_TRAP_EN
        chk("ovf", {31'b0, ovf}, {31'b0, mf.ovf});
`endif
      end else if (mem.E && xq.size() > 0) begin
        mx = xq.pop_front();
        chk("S", {31'b0, mem.S}, {31'b0, mx.s});
        if (mx.s || mx.lw) chk("addr_in", {2'b0, mem.addr_in}, {2'b0, mx.addr});
        if (mx.s) begin
          last_saddr = {2'b0, mem.addr_in};
          chk("data_in", mem.data_in, mx.data);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = '0;
    m_icnt = '0;
    m_ill = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.E = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Architectural effect of one instruction, then one fetch + one execute cycle on the DUT.
  task automatic issue(input logic [31:0] ins);
    fexp_t f;
    xexp_t x;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [31:0] pc = m_pc;
    logic [31:0] a = m_reg[ins[25:21]];
    logic [31:0] b = m_reg[ins[20:16]];
    logic [31:0] si = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zi = {16'h0, ins[15:0]};
    logic [31:0] pc4 = m_pc + 32'd4;
    logic [31:0] ea = a + si;
    logic [31:0] res = '0;
    logic [4:0] dst = op == 6'h00 ? ins[15:11] : ins[20:16];
    bit wr = 1'b1, ovfl = 1'b0;
    f.npc = pc4;
    if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) f.npc = pc4 + (si << 2);
    if (op == 6'h02) f.npc = {pc4[31:28], ins[25:0], 2'b00};
    f.outr = m_reg[5];
    f.icnt = m_icnt;
    f.ill = m_ill;
    f.ovf = m_ovf;
    x.s = op == 6'h2B;
    x.lw = op == 6'h23;
    x.addr = ea[31:2];
    x.data = b;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: begin
          res = a + b;
          ovfl = fn == 6'h20 && (longint'($signed(a)) + longint'($signed(b))) != longint'($signed(res));
        end
        6'h22, 6'h23: begin
          res = a - b;
          ovfl = fn == 6'h22 && (longint'($signed(a)) - longint'($signed(b))) != longint'($signed(res));
        end
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2A: res = $signed(a) < $signed(b) ? 32'd1 : 32'd0;
        6'h2B: res = a < b ? 32'd1 : 32'd0;
        6'h00: res = b << ins[10:6];
        default: begin
          wr = 1'b0;
          m_ill = 1'b1;
        end
      endcase
      6'h08: begin
        res = a + si;
        ovfl = (longint'($signed(a)) + longint'($signed(si))) != longint'($signed(res));
      end
      6'h09: res = a + si;
      6'h0C: res = a & zi;
      6'h0D: res = a | zi;
      6'h0F: res = {ins[15:0], 16'h0};
      6'h0A: res = $signed(a) < $signed(si) ? 32'd1 : 32'd0;
      6'h23: res = m_dmem[ea[7:2]];
      6'h2B: begin
        wr = 1'b0;
        m_dmem[ea[7:2]] = b;
      end
      6'h04, 6'h05, 6'h02: wr = 1'b0;
      default: begin
        wr = 1'b0;
        m_ill = 1'b1;
      end
    endcase
`ifdef EXEC_OVF_TRAP_EN
    if (ovfl) begin
      wr = 1'b0;
      m_ovf = 1'b1;
    end
`endif
    if (wr && dst != 5'd0) m_reg[dst] = res;
    m_icnt = m_icnt + 32'd1;
    m_pc = f.npc;
    fq.push_back(f);
    xq.push_back(x);
    mem.I = ins;
    mem.PC = pc;
    mem.E = 1'b0;
    @(posedge clk);
    #1 mem.E = 1'b1;
    @(posedge clk);
    #1 mem.E = 1'b0;
  endtask

  task automatic run(input logic [31:0] base, input int steps);
    int idx;
    m_pc = base;
    repeat (steps) begin
      idx = int'((m_pc - base) >> 2);
      issue(idx >= 0 && idx < prog.size() ? prog[idx] : 32'h0);
    end
  endtask

  task automatic rand_instr(output logic [31:0] ins);
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [15:0] boff = 16'(int'($urandom_range(0, 6)) - 3);
    case ($urandom_range(0, 14))
      0: ins = ri(6'h09, rs, rt, imm);
      1: ins = ri(6'h08, rs, rt, imm);
      2: ins = ri(6'h0C, rs, rt, imm);
      3: ins = ri(6'h0D, rs, rt, imm);
      4: ins = ri(6'h0F, rs, rt, imm);
      5: ins = ri(6'h0A, rs, rt, imm);
      6: ins = ri(6'h23, rs, rt, imm);
      7: ins = ri(6'h2B, rs, rt, imm);
      8: ins = ri(6'h04, rs, rt, boff);
      9: ins = ri(6'h05, rs, rt, boff);
      10: ins = {6'h02, 26'($urandom)};
      14: ins = $urandom_range(0, 1) ? {6'h3F, 26'($urandom)} : rr(rs, rt, rd, 5'd0, 6'h07);
      default: ins = rr(rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 8)]);
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    int s0;
    rst = 1'b1;
    mem.E = 1'b0;
    mem.I = '0;
    mem.PC = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("reset out_reg", out_reg, 32'h0);
    chk("reset instret", instret, 32'h0);
    chk("reset illegal", {31'b0, illegal}, 32'h0);

    prog = '{ri(6'h09, 0, 4, 16'd6), ri(6'h09, 0, 1, 16'd0), ri(6'h09, 0, 2, 16'd0),
             ri(6'h09, 1, 1, 16'd1), rr(2, 1, 2, 0, 6'h21), ri(6'h05, 1, 4, 16'hFFFD),
             rr(2, 0, 5, 0, 6'h21)};
    run(32'h0, 22);
    chk("sum out_reg", out_reg, 32'd21);
    chk("sum instret", instret, 32'd22);
    chk("sum illegal", {31'b0, illegal}, 32'h0);

    do_reset();
    s0 = s_cnt;
    prog = '{ri(6'h09, 0, 1, 16'h40), ri(6'h09, 0, 2, 16'h1234), ri(6'h2B, 1, 2, 16'h0),
             ri(6'h23, 1, 3, 16'h0), rr(3, 0, 5, 0, 6'h21)};
    run(32'h100, 5);
    chk("store cycles", 32'(s_cnt - s0), 32'd1);
    chk("store addr", last_saddr, 32'h10);
    chk("load r3", out_reg, 32'h1234);

    do_reset();
    prog = '{ri(6'h09, 0, 5, 16'd9), ri(6'h09, 0, 0, 16'd7), rr(0, 0, 5, 0, 6'h21)};
    run(32'h200, 2);
    chk("r0 write instret", instret, 32'd2);
    run(32'h200, 3);
    chk("r0 reads zero", out_reg, 32'h0);

    prog = '{ri(6'h04, 0, 0, 16'd3)};
    run(32'h20, 1);
    chk("beq target", last_npc, 32'h30);
    prog = '{{6'h02, 26'h100}};
    run(32'h30, 1);
    chk("j target", last_npc, 32'h400);

    prog = '{ri(6'h09, 0, 5, 16'd9), {6'h3F, 26'h0}};
    run(32'h400, 2);
    chk("illegal set", {31'b0, illegal}, 32'd1);
    chk("illegal no write", out_reg, 32'd9);
    chk("illegal next_pc", last_npc, 32'h408);
    do_reset();
    chk("illegal cleared", {31'b0, illegal}, 32'h0);

    prog = '{ri(6'h0F, 0, 1, 16'h7FFF), ri(6'h0D, 1, 1, 16'hFFFF), ri(6'h09, 0, 2, 16'd1),
             ri(6'h09, 0, 5, 16'h55), rr(1, 2, 5, 0, 6'h20)};
    run(32'h500, 5);
`ifdef EXEC_OVF_TRAP_EN
    chk("ovf rd kept", out_reg, 32'h55);
    chk("ovf flag", {31'b0, ovf}, 32'd1);
`else
    chk("ovf wraps", out_reg, 32'h80000000);
`endif

    mem.I = ri(6'h2B, 0, 5, 16'h0);
    mem.PC = 32'h600;
    mem.E = 1'b0;
    @(posedge clk);
    #1 mem.E = 1'b1;
    rst = 1'b1;
    #1 chk("S forced low in rst", {31'b0, mem.S}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem.E = 1'b0;
    model_reset();
    chk("mid-exec rst out_reg", out_reg, 32'h0);
    chk("mid-exec rst instret", instret, 32'h0);

    m_pc = {$urandom_range(0, 255), 2'b00};
    repeat (400) begin
      rand_instr(ins);
      issue(ins);
    end
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(fq.size() + xq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
